// File: rtl/tt_sel_pkg.sv
// Shared definitions for the spine select/enable sequencer.
package tt_sel_pkg;

    // Spine select field width; tied to the spine encoding, not configurable.
    localparam int unsigned SEL_W = 10;

    // Width of the guard/settle delay counter.
    localparam int unsigned CNT_W = 8;

    // Select word layout: {row[3:0], col_lsb, half, col[3:0]}.
    localparam int unsigned ROW_MSB     = 9;
    localparam int unsigned ROW_LSB     = 6;
    localparam int unsigned COL_LSB_BIT = 5;
    localparam int unsigned HALF_BIT    = 4;
    localparam int unsigned COL_MSB     = 3;
    localparam int unsigned COL_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DISARM = 2'd1,
        ST_SWITCH = 2'd2,
        ST_ARM    = 2'd3
    } sel_state_e;

    // Next select for a single-step increment; wraps modulo 2^SEL_W.
    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s);
        return s + SEL_W'(1);
    endfunction

    // Row field of a select word.
    function automatic logic [ROW_MSB-ROW_LSB:0] sel_row(input logic [SEL_W-1:0] s);
        return s[ROW_MSB:ROW_LSB];
    endfunction

endpackage

// File: rtl/tt_sel_ctrl_dly.sv
// Loadable 8-bit down-counter with a done flag, shared by guard and settle phases.
module tt_sel_dly
    import tt_sel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sel_ctrl.sv
// Break-before-make sequencer for the spine select/enable fields.
module tt_sel_ctrl
    import tt_sel_pkg::*;
#(
    parameter int unsigned GUARD_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_ena,
    input  logic             inc,
    output logic [SEL_W-1:0] spine_sel,
    output logic             spine_ena,
    output logic             busy
);

    if (GUARD_CYC < 1 || GUARD_CYC > 255) begin : g_bad_guard
        $error("tt_sel_ctrl: GUARD_CYC must be in 1..255");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
        $error("tt_sel_ctrl: SETTLE_CYC must be in 1..255");
    end

    localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    sel_state_e       state_q, state_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             ena_q, ena_d;
    logic             intent_q, intent_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;

    tt_sel_dly u_dly (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q != ST_IDLE);
    assign spine_sel = sel_q;
    assign spine_ena = ena_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tgt_q    <= '0;
            sel_q    <= '0;
            ena_q    <= 1'b0;
            intent_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            sel_q    <= sel_d;
            ena_q    <= ena_d;
            intent_q <= intent_d;
        end
    end

    // Next-state logic. The enable register is loaded on the transition into
    // ARM so that spine_ena is already valid during the ARM cycle itself.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        sel_d    = sel_q;
        ena_d    = ena_q;
        intent_d = intent_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    tgt_d    = req_sel;
                    intent_d = req_ena;
                    if (req_sel != sel_q) begin
                        state_d  = ST_DISARM;
                        ena_d    = 1'b0;
                        cnt_load = 1'b1;
                        cnt_val  = GUARD_LD;
                    end else begin
                        state_d = ST_ARM;
                        ena_d   = req_ena;
                    end
                end else if (inc) begin
                    tgt_d    = sel_step(sel_q);
                    state_d  = ST_DISARM;
                    ena_d    = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = GUARD_LD;
                end
            end
            ST_DISARM: begin
                ena_d = 1'b0;
                if (cnt_done) begin
                    state_d  = ST_SWITCH;
                    sel_d    = tgt_q;
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LD;
                end
            end
            ST_SWITCH: begin
                ena_d = 1'b0;
                if (cnt_done) begin
                    state_d = ST_ARM;
                    ena_d   = intent_q;
                end
            end
            ST_ARM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tt_sel_ctrl.sv
// Directed and soak bench for tt_sel_ctrl.
module tb_tt_sel_ctrl;

    localparam int unsigned GUARD  = 4;
    localparam int unsigned SETTLE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] req_sel = '0;
    logic       req_ena = 1'b0;
    logic       inc = 1'b0;
    logic [9:0] spine_sel;
    logic       spine_ena;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    tt_sel_ctrl #(.GUARD_CYC(GUARD), .SETTLE_CYC(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_ena   (req_ena),
        .inc       (inc),
        .spine_sel (spine_sel),
        .spine_ena (spine_ena),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for the sequencer to return to IDLE.
    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (busy) begin
            fails++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", tag, busy, k);
        end
    endtask

    // Invariant monitor: sel stable while enabled, settle time before enable.
    logic [9:0] prev_sel = '0;
    logic       prev_ena = 1'b0;
    int         since    = 255;
    always @(negedge clk) begin
        if (rst) begin
            since = SETTLE;
        end else begin
            if (spine_sel != prev_sel) since = 0;
            else if (since < 255) since++;
            checks++;
            if (prev_ena && spine_ena && spine_sel != prev_sel) begin
                fails++;
                $display("FAIL inv_sel_while_ena: sel %h -> %h with ena 1", prev_sel, spine_sel);
            end
            if (spine_ena && since < SETTLE) begin
                fails++;
                $display("FAIL inv_settle: ena 1 only %0d cycles after sel change, required >= %0d",
                         since, SETTLE);
            end
            if (spine_ena && !prev_ena && !busy) begin
                fails++;
                $display("FAIL inv_rise_in_arm: ena rose with busy %b, required 1", busy);
            end
        end
        prev_sel = spine_sel;
        prev_ena = spine_ena;
    end

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_ready_in_reset: got %b required 0", req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (spine_sel !== 10'h000 || spine_ena !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: sel=%h ena=%b ready=%b busy=%b required 000 0 1 0",
                     spine_sel, spine_ena, req_ready, busy);
        end
    endtask

    // Issues a request in the current cycle (T); returns in T+1.
    task automatic issue(input logic [9:0] s, input logic e, input logic with_inc);
        req_valid = 1'b1;
        req_sel   = s;
        req_ena   = e;
        inc       = with_inc;
        tick();
        req_valid = 1'b0;
        inc       = 1'b0;
    endtask

    task automatic test_request();
        issue(10'h2C5, 1'b1, 1'b0);                       // now T+1
        checks++;
        if (spine_ena !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL req_t1: ena=%b busy=%b ready=%b required 0 1 0", spine_ena, busy, req_ready);
        end
        tick(3);                                          // T+4
        checks++;
        if (spine_sel !== 10'h000) begin
            fails++;
            $display("FAIL req_sel_early: got %h required 000 at T+4", spine_sel);
        end
        tick();                                           // T+5
        checks++;
        if (spine_sel !== 10'h2C5 || spine_ena !== 1'b0) begin
            fails++;
            $display("FAIL req_sel_t5: sel=%h ena=%b required 2c5 0", spine_sel, spine_ena);
        end
        tick(7);                                          // T+12
        checks++;
        if (spine_ena !== 1'b0) begin
            fails++;
            $display("FAIL req_ena_early: got %b required 0 at T+12", spine_ena);
        end
        tick();                                           // T+13
        checks++;
        if (spine_ena !== 1'b1 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL req_ena_t13: ena=%b ready=%b required 1 0", spine_ena, req_ready);
        end
        tick();                                           // T+14
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || spine_sel !== 10'h2C5) begin
            fails++;
            $display("FAIL req_ready_t14: ready=%b busy=%b sel=%h required 1 0 2c5",
                     req_ready, busy, spine_sel);
        end
    endtask

    task automatic test_inc_wrap();
        issue(10'h3FF, 1'b1, 1'b0);
        wait_idle("wrap_setup");
        checks++;
        if (spine_sel !== 10'h3FF || spine_ena !== 1'b1) begin
            fails++;
            $display("FAIL wrap_setup: sel=%h ena=%b required 3ff 1", spine_sel, spine_ena);
        end
        inc = 1'b1;
        tick();                                           // T+1
        inc = 1'b0;
        checks++;
        if (spine_ena !== 1'b0 || spine_sel !== 10'h3FF) begin
            fails++;
            $display("FAIL wrap_disarm: sel=%h ena=%b required 3ff 0", spine_sel, spine_ena);
        end
        tick(4);                                          // T+5
        checks++;
        if (spine_sel !== 10'h000 || spine_ena !== 1'b0) begin
            fails++;
            $display("FAIL wrap_sel: sel=%h ena=%b required 000 0", spine_sel, spine_ena);
        end
        tick(8);                                          // T+13
        checks++;
        if (spine_ena !== 1'b1 || spine_sel !== 10'h000) begin
            fails++;
            $display("FAIL wrap_rearm: sel=%h ena=%b required 000 1", spine_sel, spine_ena);
        end
        tick();
    endtask

    task automatic test_collision_same();
        issue(10'h010, 1'b0, 1'b1);
        wait_idle("collide");
        checks++;
        if (spine_sel !== 10'h010 || spine_ena !== 1'b0) begin
            fails++;
            $display("FAIL collide_final: sel=%h ena=%b required 010 0", spine_sel, spine_ena);
        end
        issue(10'h010, 1'b1, 1'b0);                       // same address: T+1
        checks++;
        if (spine_ena !== 1'b1 || busy !== 1'b1 || spine_sel !== 10'h010) begin
            fails++;
            $display("FAIL same_addr_t1: sel=%h ena=%b busy=%b required 010 1 1",
                     spine_sel, spine_ena, busy);
        end
        tick();                                           // T+2
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL same_addr_t2: busy=%b ready=%b required 0 1", busy, req_ready);
        end
        issue(10'h010, 1'b1, 1'b0);                       // identical request
        checks++;
        if (busy !== 1'b1 || spine_ena !== 1'b1 || spine_sel !== 10'h010) begin
            fails++;
            $display("FAIL ident_t1: sel=%h ena=%b busy=%b required 010 1 1", spine_sel, spine_ena, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || spine_ena !== 1'b1 || spine_sel !== 10'h010) begin
            fails++;
            $display("FAIL ident_t2: sel=%h ena=%b busy=%b required 010 1 0", spine_sel, spine_ena, busy);
        end
    endtask

    task automatic test_reset_mid_switch();
        issue(10'h155, 1'b1, 1'b0);                       // T+1
        tick(6);                                          // T+7, two cycles into settle
        checks++;
        if (spine_sel !== 10'h155 || spine_ena !== 1'b0) begin
            fails++;
            $display("FAIL midsw_pre: sel=%h ena=%b required 155 0", spine_sel, spine_ena);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (spine_sel !== 10'h000 || spine_ena !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL midsw_reset: sel=%h ena=%b busy=%b ready=%b required 000 0 0 1",
                     spine_sel, spine_ena, busy, req_ready);
        end
        issue(10'h0AA, 1'b1, 1'b0);
        wait_idle("midsw_follow");
        checks++;
        if (spine_sel !== 10'h0AA || spine_ena !== 1'b1) begin
            fails++;
            $display("FAIL midsw_follow: sel=%h ena=%b required 0aa 1", spine_sel, spine_ena);
        end
    endtask

    // Random requests and increments; inputs are also toggled while busy to
    // show they are ignored outside IDLE.
    task automatic test_soak();
        logic [9:0] exp_sel;
        logic       exp_ena;
        int         cyc;
        int         k;
        exp_sel = spine_sel;
        exp_ena = spine_ena;
        cyc = 0;
        while (cyc < 10000) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
                cyc++;
            end else if ($urandom_range(0, 2) == 0) begin
                inc = 1'b1;
                exp_sel = exp_sel + 10'd1;
                tick();
                inc = 1'b0;
                cyc++;
            end else begin
                req_valid = 1'b1;
                req_sel   = ($urandom_range(0, 3) == 0) ? exp_sel : 10'($urandom_range(0, 1023));
                req_ena   = 1'($urandom_range(0, 1));
                inc       = 1'($urandom_range(0, 1));
                exp_sel   = req_sel;
                exp_ena   = req_ena;
                tick();
                req_valid = 1'b0;
                inc       = 1'b0;
                cyc++;
            end
            k = 0;
            while (busy && k < 100) begin
                req_valid = 1'($urandom_range(0, 1));
                req_sel   = 10'($urandom_range(0, 1023));
                req_ena   = 1'($urandom_range(0, 1));
                inc       = 1'($urandom_range(0, 1));
                tick();
                k++;
                cyc++;
            end
            req_valid = 1'b0;
            inc       = 1'b0;
            checks++;
            if (busy || spine_sel !== exp_sel || spine_ena !== exp_ena) begin
                fails++;
                $display("FAIL soak_final: busy=%b sel=%h ena=%b required busy 0 sel %h ena %b",
                         busy, spine_sel, spine_ena, exp_sel, exp_ena);
                if (busy) break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_request();
        test_inc_wrap();
        test_collision_same();
        test_reset_mid_switch();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tt_sel_ctrl.md
Name: tt_sel_ctrl

Overview:
Sequencer that owns the spine select/enable fields feeding every row mux: the 10-bit select and the 1-bit enable.
- Accepts address/enable requests over a valid/ready handshake, plus single-step increment pulses.
- Applies break-before-make: the enable is dropped, the select changes, the select is allowed to settle, then the enable is re-armed.
- Sits in the controller next to the spine driver; no user module ever sees enable asserted while the select is in transit.

Parameters:
GUARD_CYC, 4, cycles spine_ena is held low before spine_sel may change (range 1..255)
SETTLE_CYC, 8, cycles spine_sel is held stable before spine_ena may rise (range 1..255)
SEL_W, 10, select width; fixed to spine select field width, not to be overridden

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready
req_sel  input  SEL_W  target select value {row[3:0], col_lsb, half, col[3:0]} as the spine encodes it
req_ena  input  1  enable the target after selection
inc  input  1  single-cycle pulse: step to spine_sel+1, keep current enable intent
spine_sel  output  SEL_W  spine select field
spine_ena  output  1  spine enable field
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, spine_sel=0, spine_ena=0, ena_intent=0, counter=0, req_ready=1, busy=0. rst mid-sequence aborts immediately with the same values on the next cycle.
- req_ready = (state==IDLE) & ~rst; combinational from state only.
- States: IDLE, DISARM, SWITCH, ARM.
- IDLE, accept at cycle T:
  - Capture tgt_sel=req_sel and ena_intent=req_ena.
  - If tgt_sel != spine_sel: go to DISARM, load counter=GUARD_CYC-1, and drive spine_ena=0 from T+1.
  - If tgt_sel == spine_sel: go to ARM; spine_ena=ena_intent from T+1; no guard/settle.
- IDLE, inc pulse with no accept: tgt_sel=spine_sel+1, wrapping 1023->0 modulo 2^SEL_W. ena_intent is unchanged. Always takes the DISARM path.
- Simultaneous req accept and inc: the request wins; inc is dropped.
- inc outside IDLE is ignored; there is no queuing.
- DISARM: spine_ena=0. Count down; at counter==0 go to SWITCH, load spine_sel=tgt_sel and counter=SETTLE_CYC-1.
  - spine_sel therefore changes at T+1+GUARD_CYC.
- SWITCH: spine_ena=0 and spine_sel stable. At counter==0 go to ARM.
- ARM: spine_ena<=ena_intent, then go to IDLE the following cycle.
  - Enable rises at T+1+GUARD_CYC+SETTLE_CYC.
  - req_ready returns 1 one cycle later.
- Invariants (assertable):
  - spine_sel never changes while spine_ena=1.
  - spine_ena=1 never occurs within SETTLE_CYC cycles after a spine_sel change.
  - spine_ena only rises in ARM.
- Request with req_ena=0 to a different address: full guard/settle sequence, and spine_ena stays 0 at the end.
- Request identical to the current state (same sel, same ena): takes ARM, 2-cycle busy pulse, outputs unchanged.
- Counters are 8-bit. Parameters outside 1..255 are an elaboration error.

Decomposition:
- Shared package tt_sel_pkg:
  - state enum encoding (IDLE=0, DISARM=1, SWITCH=2, ARM=3)
  - SEL_W constant
  - field-extraction localparams for row/half/column bits of the select word
- One natural sub-module: tt_sel_dly, an 8-bit loadable down-counter with a done flag. It is instanced once and reused for both the guard and settle phases.
- FSM and output registers stay in tt_sel_ctrl.

Test Plan:
- Reset then idle: rst held 3 cycles -> spine_sel=0, spine_ena=0, req_ready=1, busy=0.
- Request at T: req_sel=0x2C5, req_ena=1, GUARD=4, SETTLE=8 ->
  - spine_ena=0 from T+1
  - spine_sel=0x2C5 at T+5
  - spine_ena=1 at T+13
  - req_ready=1 at T+14
- Increment with wrap: spine_sel=0x3FF enabled, inc pulse -> spine_ena drops, spine_sel=0x000 after guard, spine_ena=1 after settle.
- Collision and same-address cases:
  - inc and req_valid(req_sel=0x010, req_ena=0) in the same cycle -> request wins; final spine_sel=0x010, spine_ena=0.
  - Then req_sel=0x010, req_ena=1 -> spine_ena=1 at T+1, no guard.
- Reset mid-SWITCH: rst asserted 2 cycles into settle -> next cycle spine_sel=0, spine_ena=0, state IDLE; a follow-up request sequences normally.
- Random soak: 10k cycles of random requests and inc pulses with the invariant assertions enabled -> zero violations. Each accepted request ends with spine_sel=req_sel and spine_ena=req_ena.
